// File: rtl/exp7_pkg.sv
// exp7_pkg - shared definitions for the play-detector input stage.
//   estado_det_t     : 2-bit FSM state code, also exported on db_estado
//   N_BOTOES_DEFAULT : default number of player buttons
//   DEBOUNCE_50MHZ   : stable cycles for 1 ms of debounce at 50 MHz
package exp7_pkg;

  typedef enum logic [1:0] {
    OCIOSO       = 2'b00,
    FILTRA_PRESS = 2'b01,
    PRESSIONADO  = 2'b10,
    FILTRA_SOLTA = 2'b11
  } estado_det_t;

  localparam int N_BOTOES_DEFAULT = 4;
  localparam int DEBOUNCE_50MHZ   = 50000;

endpackage

// File: rtl/exp7_contador_filtro.sv
// exp7_contador_filtro - clearable up-counter used to time the debounce
// windows.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous active-high reset, count <= 0
//   clear  : synchronous clear, count <= 0
//   enable : count up by one
//   fim    : high while count == DEBOUNCE_CYCLES-1
module exp7_contador_filtro #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int W = $clog2(DEBOUNCE_CYCLES);

  logic [W-1:0] count;

  // Holds at the terminal value instead of wrapping; the FSM leaves the
  // filtering state on that same edge anyway.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !fim) begin
      count <= count + W'(1);
    end
  end

  assign fim = (count == W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/exp7_detector_jogada.sv
// exp7_detector_jogada - debounces the raw player buttons and emits one
// jogada pulse per accepted press, plus the held one-hot code of the press.
// Ports:
//   clock       : system clock, rising edge
//   reset       : synchronous active-high reset
//   botoes      : raw button levels, 1 = pressed
//   limpa       : synchronous clear of jogada_code, returns FSM to OCIOSO
//   jogada      : one-cycle pulse when a press is accepted
//   jogada_code : one-hot code of the last accepted button
//   multiplo    : registered flag, filtered input non-zero and not one-hot
//   db_estado   : current FSM state
// Optional feature: define DETECTOR_SYNC_EN to pass botoes through a
// 2-flop synchronizer before use (adds 2 cycles of latency).
module exp7_detector_jogada
  import exp7_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                limpa,
  output logic                jogada,
  output logic [N_BOTOES-1:0] jogada_code,
  output logic                multiplo,
  output logic [1:0]          db_estado
);

  logic [N_BOTOES-1:0] v;
  logic [N_BOTOES-1:0] cap;
  logic                valido;
  logic                igual;
  logic                zero;
  logic                fim;
  logic                cnt_clear;
  logic                cnt_enable;
  logic                captura;
  logic                aceita;
  estado_det_t         estado;
  estado_det_t         proximo;

`ifdef DETECTOR_SYNC_EN
  logic [N_BOTOES-1:0] sync_a;
  logic [N_BOTOES-1:0] sync_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= botoes;
      sync_b <= sync_a;
    end
  end

  assign v = sync_b;
`else
  assign v = botoes;
`endif

  // A value with a single bit set clears to zero when ANDed with itself minus one.
  assign valido = (v != '0) && ((v & (v - 1'b1)) == '0);
  assign igual  = (v == cap);
  assign zero   = (v == '0);

  exp7_contador_filtro #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .fim   (fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = estado;
    if (limpa) begin
      proximo = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido) proximo = FILTRA_PRESS;
        end
        FILTRA_PRESS: begin
          if (igual) begin
            if (fim) proximo = PRESSIONADO;
          end else if (!valido) begin
            proximo = OCIOSO;
          end
        end
        PRESSIONADO: begin
          if (zero) proximo = FILTRA_SOLTA;
        end
        FILTRA_SOLTA: begin
          if (!zero) begin
            proximo = PRESSIONADO;
          end else if (fim) begin
            proximo = OCIOSO;
          end
        end
        default: proximo = OCIOSO;
      endcase
    end
  end

  // limpa wins over acceptance: aceita stays low whenever limpa is high.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    captura    = 1'b0;
    aceita     = 1'b0;
    if (limpa) begin
      cnt_clear = 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido) begin
            captura   = 1'b1;
            cnt_clear = 1'b1;
          end
        end
        FILTRA_PRESS: begin
          if (igual) begin
            cnt_enable = 1'b1;
            aceita     = fim;
          end else if (valido) begin
            captura   = 1'b1;
            cnt_clear = 1'b1;
          end
        end
        PRESSIONADO: begin
          if (zero) cnt_clear = 1'b1;
        end
        FILTRA_SOLTA: begin
          if (zero) cnt_enable = 1'b1;
        end
        default: cnt_clear = 1'b1;
      endcase
    end
  end

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      cap         <= '0;
      jogada_code <= '0;
      jogada      <= 1'b0;
      multiplo    <= 1'b0;
    end else begin
      jogada   <= aceita;
      multiplo <= !zero && !valido;
      if (limpa) begin
        cap         <= '0;
        jogada_code <= '0;
      end else begin
        if (captura) cap <= v;
        if (aceita) jogada_code <= cap;
      end
    end
  end

endmodule

// File: tb/tb_exp7_detector_jogada.sv
// tb_exp7_detector_jogada - self-checking bench for exp7_detector_jogada
// with DEBOUNCE_CYCLES=4, N_BOTOES=4, synchronizer disabled.
module tb_exp7_detector_jogada;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          limpa = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic          jogada;
  logic [NB-1:0] jogada_code;
  logic          multiplo;
  logic [1:0]    db_estado;

  always #5 clock = ~clock;

  exp7_detector_jogada #(
    .N_BOTOES(NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .limpa      (limpa),
    .jogada     (jogada),
    .jogada_code(jogada_code),
    .multiplo   (multiplo),
    .db_estado  (db_estado)
  );

  int errors = 0;
  int checks = 0;

  // Reference model in terms of stable run lengths: a press is accepted after
  // DB+1 consecutive identical one-hot samples while released; a release is
  // accepted after DB+1 consecutive zero samples while held.
  bit            m_held = 0;
  int            m_run  = 0;
  int            m_zrun = 0;
  logic [NB-1:0] m_cand = '0;
  logic [NB-1:0] m_code = '0;
  logic          m_jog  = 1'b0;
  logic          m_mult = 1'b0;

  function automatic void modelStep(input logic rst, input logic lmp, input logic [NB-1:0] v);
    if (rst) begin
      m_held = 0; m_run = 0; m_zrun = 0;
      m_cand = '0; m_code = '0; m_jog = 1'b0; m_mult = 1'b0;
    end else begin
      m_mult = ($countones(v) > 1);
      m_jog  = 1'b0;
      if (lmp) begin
        m_held = 0; m_run = 0; m_code = '0;
      end else if (!m_held) begin
        if ($countones(v) == 1) begin
          if (m_run > 0 && v == m_cand) m_run++;
          else begin
            m_cand = v;
            m_run  = 1;
          end
          if (m_run == DB + 1) begin
            m_jog = 1'b1; m_code = m_cand; m_held = 1; m_zrun = 0; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (v == '0) begin
          m_zrun++;
          if (m_zrun == DB + 1) begin
            m_held = 0; m_run = 0;
          end
        end else begin
          m_zrun = 0;
        end
      end
    end
  endfunction

  function automatic logic [1:0] modelEstado();
    if (!m_held) return (m_run == 0) ? 2'b00 : 2'b01;
    return (m_zrun == 0) ? 2'b10 : 2'b11;
  endfunction

  task automatic checkField(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ej, input logic [3:0] ec,
                             input logic em, input logic [1:0] es);
    checkField({name, ".jogada"},      {3'b0, jogada},    {3'b0, ej});
    checkField({name, ".jogada_code"}, jogada_code,       ec);
    checkField({name, ".multiplo"},    {3'b0, multiplo},  {3'b0, em});
    checkField({name, ".db_estado"},   {2'b0, db_estado}, {2'b0, es});
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are read
  // 1 time unit after the edge that sampled them.
  task automatic applyStimulus(input logic rst, input logic lmp, input logic [NB-1:0] btn);
    reset  = rst;
    limpa  = lmp;
    botoes = btn;
    @(posedge clock);
    #1;
    modelStep(rst, lmp, btn);
  endtask

  typedef struct {
    logic          rst;
    logic          lmp;
    logic [NB-1:0] btn;
    logic          jog;
    logic [NB-1:0] code;
    logic          mult;
    logic [1:0]    est;
  } vec_t;

  typedef struct {
    logic          rst;
    logic          lmp;
    logic [NB-1:0] btn;
  } seq_t;

  vec_t tbl[$];
  seq_t seq[$];

  function automatic void addVec(input logic r, input logic l, input logic [3:0] b, input int n,
                                 input logic j, input logic [3:0] c, input logic m, input logic [1:0] e);
    vec_t x;
    x.rst = r; x.lmp = l; x.btn = b; x.jog = j; x.code = c; x.mult = m; x.est = e;
    for (int k = 0; k < n; k++) tbl.push_back(x);
  endfunction

  function automatic void addSeq(input logic r, input logic l, input logic [3:0] b, input int n);
    seq_t x;
    x.rst = r; x.lmp = l; x.btn = b;
    for (int k = 0; k < n; k++) seq.push_back(x);
  endfunction

  task automatic runSequence(input string name, input int exp_pulses, input int exp_first,
                             input int exp_last, input logic [3:0] exp_code);
    int pulses = 0;
    int first  = -1;
    int last   = -1;
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i].rst, seq[i].lmp, seq[i].btn);
      checkOutput(name, m_jog, m_code, m_mult, modelEstado());
      if (jogada === 1'b1) begin
        pulses++;
        if (first < 0) first = i + 1;
        last = i + 1;
      end
    end
    checkInt({name, ".pulses"}, pulses, exp_pulses);
    checkInt({name, ".first_pulse_cycle"}, first, exp_first);
    checkInt({name, ".last_pulse_cycle"}, last, exp_last);
    checkField({name, ".final_code"}, jogada_code, exp_code);
    seq.delete();
  endtask

  function automatic logic [NB-1:0] pickButtons(input logic [NB-1:0] prev);
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return prev;
    if (r == 7) return '0;
    if (r == 8) return NB'(1) << $urandom_range(0, NB - 1);
    return NB'($urandom_range(0, (1 << NB) - 1));
  endfunction

  initial begin
    logic [NB-1:0] b;
    logic          r;
    logic          l;

    // reset, held 0100 press, release, clean 0010 press, multi-press, limpa
    addVec(1, 0, 4'b0100, 2, 0, 4'b0000, 0, 2'b00);
    addVec(0, 0, 4'b0100, 4, 0, 4'b0000, 0, 2'b01);
    addVec(0, 0, 4'b0100, 1, 1, 4'b0100, 0, 2'b10);
    addVec(0, 0, 4'b0100, 1, 0, 4'b0100, 0, 2'b10);
    addVec(0, 0, 4'b0000, 4, 0, 4'b0100, 0, 2'b11);
    addVec(0, 0, 4'b0000, 2, 0, 4'b0100, 0, 2'b00);
    addVec(0, 0, 4'b0010, 4, 0, 4'b0100, 0, 2'b01);
    addVec(0, 0, 4'b0010, 1, 1, 4'b0010, 0, 2'b10);
    addVec(0, 0, 4'b0010, 1, 0, 4'b0010, 0, 2'b10);
    addVec(0, 0, 4'b0011, 2, 0, 4'b0010, 1, 2'b10);
    addVec(0, 0, 4'b0000, 4, 0, 4'b0010, 0, 2'b11);
    addVec(0, 0, 4'b0000, 1, 0, 4'b0010, 0, 2'b00);
    addVec(0, 0, 4'b0001, 1, 0, 4'b0010, 0, 2'b01);
    addVec(0, 1, 4'b0001, 1, 0, 4'b0000, 0, 2'b00);
    addVec(0, 0, 4'b0001, 1, 0, 4'b0000, 0, 2'b01);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].lmp, tbl[i].btn);
      checkOutput($sformatf("table[%0d]", i), tbl[i].jog, tbl[i].code, tbl[i].mult, tbl[i].est);
    end

    // bounce on press: pulse 5 cycles after the last 0->0010 edge (index 3)
    addSeq(0, 0, 4'b0010, 2);
    addSeq(0, 0, 4'b0000, 1);
    addSeq(0, 0, 4'b0010, 12);
    runSequence("bounce_press", 1, 8, 8, 4'b0010);

    // button change while filtering, then a multi-press while held
    addSeq(0, 0, 4'b0001, 2);
    addSeq(0, 0, 4'b1000, 12);
    addSeq(0, 0, 4'b0011, 3);
    runSequence("change_multi", 1, 7, 7, 4'b1000);

    // release bounce keeps a single pulse; a later full press gives the second
    addSeq(0, 0, 4'b0100, 8);
    addSeq(0, 0, 4'b0000, 2);
    addSeq(0, 0, 4'b0100, 1);
    addSeq(0, 0, 4'b0000, 8);
    addSeq(0, 0, 4'b0001, 8);
    runSequence("release_bounce", 2, 5, 24, 4'b0001);

    // limpa on the acceptance cycle suppresses the pulse and clears the code
    addSeq(0, 0, 4'b1000, 6);
    addSeq(0, 0, 4'b0000, 6);
    addSeq(0, 0, 4'b0010, 4);
    addSeq(0, 1, 4'b0010, 1);
    addSeq(0, 0, 4'b0010, 8);
    runSequence("limpa_accept", 2, 5, 22, 4'b0010);

    // reset in mid-filter discards the press
    addSeq(0, 0, 4'b0010, 3);
    addSeq(1, 0, 4'b0010, 1);
    addSeq(0, 0, 4'b0010, 8);
    runSequence("reset_mid", 1, 9, 9, 4'b0010);

    // randomized traffic against the run-length model
    b = '0;
    for (int i = 0; i < 600; i++) begin
      b = pickButtons(b);
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 99) < 3);
      applyStimulus(r, l, b);
      checkOutput($sformatf("random[%0d]", i), m_jog, m_code, m_mult, modelEstado());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp7_detector_jogada.md
Name: exp7_detector_jogada

Overview:
- Input stage for the game control unit. Filters the raw player buttons and emits a single-cycle jogada pulse per valid press, together with the held one-hot code of the button pressed.
- Sits between the board pushbuttons and the datapath/control unit. jogada feeds the control unit's jogada input. jogada_code feeds the datapath's play register and the LED path.
- Exactly one pulse per physical press, no matter how long the button is held.

Parameters:
- N_BOTOES, 4, number of player buttons (width of botoes and jogada_code).
- DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles needed to accept a press or a release (1 ms at 50 MHz). Must be ≥2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- botoes  input  N_BOTOES  raw button levels, 1 = pressed.
- limpa  input  1  synchronous clear of jogada_code; FSM also returns to OCIOSO.
- jogada  output  1  one-cycle pulse when a press is accepted.
- jogada_code  output  N_BOTOES  one-hot code of the last accepted button; held until the next accepted press or a clear.
- multiplo  output  1  high while the filtered input is non-zero and not one-hot.
- db_estado  output  2  current FSM state encoding.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: jogada=0, jogada_code=0, multiplo=0, db_estado=00, counter=0, captured code=0, FSM=OCIOSO.
- Definitions:
  - v = botoes (or its synchronized copy, see Optional Feature).
  - valido = v is non-zero and one-hot.
  - Counter width = $clog2(DEBOUNCE_CYCLES).
- FSM states (db_estado): OCIOSO=00, FILTRA_PRESS=01, PRESSIONADO=10, FILTRA_SOLTA=11.
- OCIOSO:
  - If valido: capture cap <= v, clear counter, go to FILTRA_PRESS.
  - Otherwise: stay.
- FILTRA_PRESS:
  - If v == cap: increment counter.
  - If v == cap and counter == DEBOUNCE_CYCLES-1: go to PRESSIONADO; in the same edge register jogada_code <= cap and drive jogada=1 for exactly the next cycle (registered pulse).
  - If v != cap and v is valido: recapture cap <= v, clear counter, stay.
  - If v != cap and v is not valido: go to OCIOSO.
- PRESSIONADO:
  - If v == 0: clear counter, go to FILTRA_SOLTA.
  - Otherwise: stay. This covers a held button, a change to another button or extra buttons: no new pulse until a full release.
- FILTRA_SOLTA:
  - If v == 0: increment counter.
  - If v == 0 and counter == DEBOUNCE_CYCLES-1: go to OCIOSO.
  - If v != 0: go to PRESSIONADO (bounce on release, no pulse).
- Latency: clean press at cycle 0 (v sampled at the edge ending cycle 0) -> jogada high during cycle DEBOUNCE_CYCLES+1. jogada_code updates on the same edge that raises jogada.
- Minimum spacing between two pulses: 2·DEBOUNCE_CYCLES+2 cycles.
- multiplo: registered. It is 1 the cycle after v is sampled non-zero and not one-hot; it clears the cycle after that condition ends.
- limpa:
  - Clears jogada_code, counter and cap, forces FSM to OCIOSO and jogada=0.
  - limpa has priority over a press acceptance on the same edge; no pulse is emitted.
  - If a button is held while limpa is asserted, it is re-filtered from OCIOSO afterwards and produces a pulse.
- reset has priority over limpa. Reset mid-filter discards the press; no pulse.
- The counter never wraps: it saturates only by leaving the state at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: DETECTOR_SYNC_EN.
- Defined: botoes passes through a 2-flop synchronizer, reset to 0, before use as v. All latencies grow by 2 cycles; the first pulse comes in cycle DEBOUNCE_CYCLES+3.
- Undefined: v = botoes directly; the inputs are assumed already synchronous (testbench or upstream synchronizer).

Decomposition:
- Shared package exp7_pkg holds:
  - state localparams OCIOSO/FILTRA_PRESS/PRESSIONADO/FILTRA_SOLTA (2-bit typedef estado_det_t);
  - the default N_BOTOES;
  - the debounce constant for 50 MHz.
- One natural sub-module: exp7_contador_filtro, a clearable up-counter with terminal-count flag parameterised by DEBOUNCE_CYCLES.
- The synchronizer stays inline under the macro.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, N_BOTOES=4, macro off.
- Reset: assert reset 2 cycles with botoes=0100 -> all outputs 0, db_estado=00; after release, a held 0100 yields one pulse 5 cycles later.
- Clean press: botoes=0010 held 20 cycles -> jogada high exactly 1 cycle (cycle 5), jogada_code=0010 held after release, db_estado sequence 00→01→10→11→00.
- Bounce on press: 0010 for 2 cycles, 0000 for 1, then 0010 steady -> no pulse during the bounce, single pulse 5 cycles after the last 0→0010 edge.
- Button change while filtering and multi-press: 0001 for 2 cycles then 1000 steady -> pulse with jogada_code=1000. Input 0011 -> multiplo=1, no pulse, jogada_code unchanged.
- Release bounce and hold: hold 0100, release 2 cycles, re-press 1 cycle, release steady -> exactly one pulse total. Next press of 0001 after full release -> second pulse, jogada_code=0001.
- limpa: assert on the cycle the counter hits 3 in FILTRA_PRESS -> no pulse, jogada_code=0000, FSM=00. Button still held -> pulse 5 cycles after limpa deasserts.
